// File: rtl/stack_mem_stage.sv
// Memory-access stage: data memory, stack pointer and push-data muxing.
// Ports: control (stack, mem_rd, mem_wr, mem_data_sel, pop_*), alu_addr,
// wr_data, pc and ccr in; rd_data, pc_restore(+valid),
// ccr_restore(+valid), sp, stack_ovf and stack_unf out.
module stack_mem_stage #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 11,
  parameter int SP_INIT = 2**ADDR_W-1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stack,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [1:0]        mem_data_sel,
  input  logic              pop_pc1,
  input  logic              pop_pc2,
  input  logic              pop_ccr,
  input  logic [DATA_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [31:0]       pc,
  input  logic [2:0]        ccr,
  output logic [DATA_W-1:0] rd_data,
  output logic [31:0]       pc_restore,
  output logic              pc_restore_valid,
  output logic [2:0]        ccr_restore,
  output logic              ccr_restore_valid,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam logic [ADDR_W-1:0] SP_TOP = SP_INIT[ADDR_W-1:0];

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] sp_inc;
  logic [ADDR_W-1:0] addr;
  logic              full;
  logic              empty;
  logic              do_wr;
  logic              do_rd;
  logic              pop_ok;
  logic              push_ovf;
  logic              pop_unf;
  logic              pend;
  logic [DATA_W-1:0] word;
  logic              unused_bits;

  assign unused_bits = ^alu_addr[DATA_W-1:ADDR_W];

  assign sp_inc = sp + 1'b1;
  assign full   = (sp == '0);
  assign empty  = (sp == SP_TOP);

  always_comb begin
    wdata = '0;
    unique case (mem_data_sel)
      2'b00: wdata = wr_data;
      2'b01: wdata = DATA_W'(pc[15:0]);
      2'b10: wdata = DATA_W'(pc[31:16]);
      2'b11: wdata[2:0] = ccr;
    endcase
  end

  // push writes at sp (post-decrement), pop reads sp+1 (pre-increment)
  always_comb begin
    addr = alu_addr[ADDR_W-1:0];
    if (stack) addr = mem_wr ? sp : sp_inc;
  end

  // write wins over a simultaneous read
  assign push_ovf = stack & mem_wr & full;
  assign pop_unf  = stack & mem_rd & ~mem_wr & empty;
  assign do_wr    = mem_wr & ~push_ovf;
  assign do_rd    = mem_rd & ~mem_wr & ~pop_unf;
  assign pop_ok   = stack & do_rd;
  assign word     = mem[addr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp                <= SP_TOP;
      rd_data           <= '0;
      pc_restore        <= '0;
      pc_restore_valid  <= 1'b0;
      ccr_restore       <= '0;
      ccr_restore_valid <= 1'b0;
      stack_ovf         <= 1'b0;
      stack_unf         <= 1'b0;
      pend              <= 1'b0;
    end else begin
      pc_restore_valid  <= 1'b0;
      ccr_restore_valid <= 1'b0;
      if (push_ovf) stack_ovf <= 1'b1;
      if (pop_unf) begin
        stack_unf <= 1'b1;
        rd_data   <= '0;
      end
      if (stack & do_wr) sp <= sp - 1'b1;
      if (do_rd) rd_data <= word;
      if (pop_ok) begin
        sp <= sp_inc;
        unique case (1'b1)
          pop_ccr: begin
            ccr_restore       <= word[2:0];
            ccr_restore_valid <= 1'b1;
          end
          pop_pc2: begin
            pc_restore[31:16] <= word[15:0];
            pend              <= 1'b1;
          end
          pop_pc1: begin
            pc_restore[15:0] <= word[15:0];
            pc_restore_valid <= pend;
            pend             <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stack_mem_stage.sv
// Directed bench for stack_mem_stage: plain access, interrupt push/pop,
// underflow, overflow and reset in the middle of a pop sequence.
module tb_stack_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stack, mem_rd, mem_wr;
  logic [1:0]  mem_data_sel;
  logic        pop_pc1, pop_pc2, pop_ccr;
  logic [15:0] alu_addr, wr_data;
  logic [31:0] pc;
  logic [2:0]  ccr;
  logic [15:0] rd_data;
  logic [31:0] pc_restore;
  logic        pc_restore_valid;
  logic [2:0]  ccr_restore;
  logic        ccr_restore_valid;
  logic [10:0] sp;
  logic        stack_ovf, stack_unf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stack_mem_stage dut (
    .clk(clk), .rst(rst),
    .stack(stack), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_sel(mem_data_sel),
    .pop_pc1(pop_pc1), .pop_pc2(pop_pc2), .pop_ccr(pop_ccr),
    .alu_addr(alu_addr), .wr_data(wr_data),
    .pc(pc), .ccr(ccr),
    .rd_data(rd_data),
    .pc_restore(pc_restore), .pc_restore_valid(pc_restore_valid),
    .ccr_restore(ccr_restore), .ccr_restore_valid(ccr_restore_valid),
    .sp(sp), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stack = 0; mem_rd = 0; mem_wr = 0;
    pop_pc1 = 0; pop_pc2 = 0; pop_ccr = 0;
  endtask

  initial begin
    rst = 0; idle();
    mem_data_sel = 0; alu_addr = 0; wr_data = 0;
    pc = 0; ccr = 0;
    #12;
    chk("rst_sp", sp, 32'h7FF);
    chk("rst_rd", rd_data, 0);
    chk("rst_flags", {stack_ovf, stack_unf}, 0);
    chk("rst_valids", {pc_restore_valid, ccr_restore_valid}, 0);
    rst = 1;
    cyc();

    // plain write then read
    mem_wr = 1; alu_addr = 16'h0010; wr_data = 16'hBEEF;
    cyc();
    mem_wr = 0; mem_rd = 1;
    cyc();
    chk("plain_rd", rd_data, 16'hBEEF);
    chk("plain_sp", sp, 32'h7FF);
    idle();

    // interrupt push
    pc = 32'h0001_2345; ccr = 3'b101;
    stack = 1; mem_wr = 1;
    mem_data_sel = 2'b01; cyc();
    chk("push1_sp", sp, 32'h7FE);
    mem_data_sel = 2'b10; cyc();
    mem_data_sel = 2'b11; cyc();
    chk("push3_sp", sp, 32'h7FC);
    idle(); mem_data_sel = 0;
    mem_rd = 1;
    alu_addr = 16'h07FF; cyc(); chk("mem7ff", rd_data, 16'h2345);
    alu_addr = 16'h07FE; cyc(); chk("mem7fe", rd_data, 16'h0001);
    alu_addr = 16'h07FD; cyc(); chk("mem7fd", rd_data, 16'h0005);
    idle();

    // RTI pop
    stack = 1; mem_rd = 1; pop_ccr = 1;
    cyc();
    chk("ccr_val", ccr_restore_valid, 1);
    chk("ccr_rest", ccr_restore, 3'b101);
    chk("pop1_rd", rd_data, 16'h0005);
    chk("pop1_sp", sp, 32'h7FD);
    pop_ccr = 0; pop_pc2 = 1;
    cyc();
    chk("ccr_strobe", ccr_restore_valid, 0);
    chk("pc_early", pc_restore_valid, 0);
    chk("pop2_rd", rd_data, 16'h0001);
    pop_pc2 = 0; pop_pc1 = 1;
    cyc();
    chk("pc_val", pc_restore_valid, 1);
    chk("pc_rest", pc_restore, 32'h0001_2345);
    chk("pop3_sp", sp, 32'h7FF);
    idle();
    cyc();
    chk("pc_strobe", pc_restore_valid, 0);

    // underflow
    stack = 1; mem_rd = 1; pop_pc1 = 1;
    cyc();
    chk("unf_rd", rd_data, 0);
    chk("unf_sp", sp, 32'h7FF);
    chk("unf_flag", stack_unf, 1);
    chk("unf_valids", {pc_restore_valid, ccr_restore_valid}, 0);
    idle();
    cyc();
    chk("unf_sticky", stack_unf, 1);

    // overflow
    mem_wr = 1; alu_addr = 16'h0000; wr_data = 16'h1234;
    cyc();
    idle();
    stack = 1; mem_wr = 1;
    for (int i = 0; i < 2047; i++) begin
      wr_data = 16'(i);
      cyc();
    end
    chk("full_sp", sp, 0);
    chk("full_noovf", stack_ovf, 0);
    wr_data = 16'hAAAA;
    cyc();
    chk("ovf_sp", sp, 0);
    chk("ovf_flag", stack_ovf, 1);
    idle();
    mem_rd = 1; alu_addr = 16'h0000; cyc();
    chk("ovf_mem0", rd_data, 16'h1234);
    alu_addr = 16'h0001; cyc();
    chk("mem1", rd_data, 16'h07FE);
    idle();

    // async reset
    rst = 0; #2;
    chk("arst_sp", sp, 32'h7FF);
    chk("arst_flags", {stack_ovf, stack_unf}, 0);
    rst = 1;
    cyc();

    // reset between pop_pc2 and pop_pc1
    stack = 1; mem_wr = 1;
    mem_data_sel = 2'b01; cyc();
    mem_data_sel = 2'b10; cyc();
    mem_data_sel = 2'b11; cyc();
    idle(); mem_data_sel = 0;
    stack = 1; mem_rd = 1; pop_ccr = 1; cyc();
    pop_ccr = 0; pop_pc2 = 1; cyc();
    idle();
    rst = 0; #2;
    chk("mid_sp", sp, 32'h7FF);
    rst = 1;
    cyc();
    stack = 1; mem_wr = 1; wr_data = 16'h4321; cyc();
    idle();
    stack = 1; mem_rd = 1; pop_pc1 = 1; cyc();
    chk("nopend_val", pc_restore_valid, 0);
    chk("nopend_pc", pc_restore, 32'h0000_4321);
    chk("nopend_rd", rd_data, 16'h4321);
    idle();

    // simultaneous read and write
    mem_rd = 1; mem_wr = 1; alu_addr = 16'h0020; wr_data = 16'h5555;
    cyc();
    chk("rw_hold", rd_data, 16'h4321);
    mem_wr = 0;
    cyc();
    chk("rw_wrote", rd_data, 16'h5555);
    idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
